// File: rtl/mem_rd_arbiter_if.sv
// Read-port bundle between NUM_M requesters and one memory slave (AR/R valid/ready).
// The arbiter uses "master" (it masters the slave side); the environment uses "slave".
interface mem_rd_arbiter_if #(
    parameter int NUM_M = 2
);
    logic [NUM_M-1:0]    m_arvalid;
    logic [NUM_M*32-1:0] m_araddr;
    logic [NUM_M-1:0]    m_arready;
    logic [NUM_M-1:0]    m_rvalid;
    logic [31:0]         m_rdata;
    logic [1:0]          m_rresp;
    logic [NUM_M-1:0]    m_rready;

    logic [31:0]         s_araddr;
    logic                s_arvalid;
    logic                s_arready;
    logic [31:0]         s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rvalid;
    logic                s_rready;

    modport master (
        input  m_arvalid, m_araddr, m_rready, s_arready, s_rdata, s_rresp, s_rvalid,
        output m_arready, m_rvalid, m_rdata, m_rresp, s_araddr, s_arvalid, s_rready
    );

    modport slave (
        output m_arvalid, m_araddr, m_rready, s_arready, s_rdata, s_rresp, s_rvalid,
        input  m_arready, m_rvalid, m_rdata, m_rresp, s_araddr, s_arvalid, s_rready
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one AR/R read port among NUM_M masters, one read outstanding.
// Optional DATA-phase response timeout enabled by defining MEM_RD_ARB_TIMEOUT_EN.
module mem_rd_arbiter #(
    parameter int NUM_M   = 2,
    parameter int TIMEOUT = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_rd_arbiter_if.master         bus,
    output logic [$clog2(NUM_M)-1:0] grant_id,
    output logic                     arb_busy
);
    localparam int GW = $clog2(NUM_M);

    if (NUM_M < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mem_rd_arbiter: NUM_M must be >= 2 and TIMEOUT >= 1");
    end

`ifdef MEM_RD_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
`else
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
`endif

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] winner;
    logic [GW:0]   cand;

    // Search upward from last_grant+1; iterating from the far end lets the nearest requester win.
    always_comb begin
        winner = last_grant;
        cand   = '0;
        for (int k = NUM_M; k >= 1; k--) begin
            cand = {1'b0, last_grant} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_M)) begin
                cand = cand - (GW+1)'(NUM_M);
            end
            if (bus.m_arvalid[cand[GW-1:0]]) begin
                winner = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        bus.s_arvalid = 1'b0;
        bus.s_araddr  = '0;
        bus.s_rready  = 1'b0;
        bus.m_arready = '0;
        bus.m_rvalid  = '0;
        bus.m_rdata   = bus.s_rdata;
        bus.m_rresp   = bus.s_rresp;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_id == GW'(i)) begin
                bus.s_araddr = bus.m_araddr[32*i +: 32];
            end
        end
        case (state)
            ADDR: begin
                bus.s_arvalid           = bus.m_arvalid[grant_id];
                bus.m_arready[grant_id] = bus.s_arready;
            end
            DATA: begin
                bus.m_rvalid[grant_id] = bus.s_rvalid;
                bus.s_rready           = bus.m_rready[grant_id];
            end
`ifdef MEM_RD_ARB_TIMEOUT_EN
            // Synthesised error beat; a late slave beat is swallowed meanwhile.
            ERR: begin
                bus.m_rvalid[grant_id] = 1'b1;
                bus.m_rresp            = 2'b11;
                bus.m_rdata            = '0;
                bus.s_rready           = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign arb_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_M - 1);
`ifdef MEM_RD_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.m_arvalid) begin
                        grant_id <= winner;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.s_arvalid && bus.s_arready) begin
                        state <= DATA;
`ifdef MEM_RD_ARB_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                DATA: begin
                    if (bus.s_rvalid && bus.s_rready) begin
                        state      <= IDLE;
                        last_grant <= grant_id;
                    end
`ifdef MEM_RD_ARB_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        state <= ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
`ifdef MEM_RD_ARB_TIMEOUT_EN
                ERR: begin
                    if (bus.m_rready[grant_id]) begin
                        state      <= IDLE;
                        last_grant <= grant_id;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Scoreboard bench for mem_rd_arbiter: directed reads, negedge monitor pops expected AR/R beats.
`timescale 1ns/1ps
module tb_mem_rd_arbiter;
    localparam int NUM_M = 2;
    localparam int TMO   = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_rd_arbiter_if #(.NUM_M(NUM_M)) bus ();
    logic [0:0] grant_id;
    logic       arb_busy;

    mem_rd_arbiter #(.NUM_M(NUM_M), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id), .arb_busy(arb_busy)
    );

    typedef struct { int m; logic [31:0] addr; } ar_t;
    typedef struct { int m; logic [31:0] data; logic [1:0] resp; } r_t;

    ar_t         exp_ar[$];
    r_t          exp_r[$];
    logic [33:0] sq[$];
    logic [31:0] mq[NUM_M][$];

    int vectors = 0;
    int miscompares = 0;
    int ar_wait = 0, r_wait = 0;
    int cyc = 0, rv_cycles = 0, ar_cyc = 0, r_cyc = 0, cur_m = 0;

    logic             n_rst = 1'b1, n_s_arvalid = 1'b0, n_s_ar_hs = 1'b0, n_s_r_hs = 1'b0;
    logic [NUM_M-1:0] n_ar_hs = '0, n_r_hs = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples handshakes at negedge and scores them against the expected queues.
    always @(negedge clk) begin
        ar_t ea;
        r_t  er;
        cyc++;
        n_rst       = rst;
        n_s_arvalid = bus.s_arvalid;
        n_s_ar_hs   = bus.s_arvalid && bus.s_arready;
        n_s_r_hs    = bus.s_rvalid && bus.s_rready;
        n_ar_hs     = bus.m_arvalid & bus.m_arready;
        n_r_hs      = bus.m_rvalid & bus.m_rready;
        if (!rst) begin
            if (n_s_ar_hs) begin
                ar_cyc = cyc;
                if (exp_ar.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL ar_unexpected: got addr 0x%0h, expected no AR", bus.s_araddr);
                end else begin
                    ea = exp_ar.pop_front();
                    check("ar_addr", bus.s_araddr, ea.addr);
                    check("ar_grant_id", grant_id, ea.m);
                    check("ar_m_arready", bus.m_arready, 64'(1) << ea.m);
                    cur_m = ea.m;
                end
            end
            if (bus.m_rvalid != '0) begin
                rv_cycles++;
                check("rvalid_target", bus.m_rvalid, 64'(1) << cur_m);
            end
            for (int i = 0; i < NUM_M; i++) begin
                if (n_r_hs[i]) begin
                    r_cyc = cyc;
                    if (exp_r.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL r_unexpected: got beat to master %0d, expected none", i);
                    end else begin
                        er = exp_r.pop_front();
                        check("r_master", i, er.m);
                        check("r_data", bus.m_rdata, er.data);
                        check("r_resp", bus.m_rresp, er.resp);
                    end
                end
            end
        end
    end

    // Master and slave models, driven 1ns after each rising edge.
    initial begin
        int mph[NUM_M];
        int sph, scnt;
        logic [33:0] beat;
        sph = 0; scnt = 0;
        for (int i = 0; i < NUM_M; i++) mph[i] = 0;
        bus.m_arvalid = '0; bus.m_araddr = '0;
        bus.s_arready = 1'b0; bus.s_rvalid = 1'b0; bus.s_rdata = '0; bus.s_rresp = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_M; i++) begin
                if (n_rst) begin
                    mph[i] = 0;
                    bus.m_arvalid[i] = 1'b0;
                end else begin
                    if (mph[i] == 1 && n_ar_hs[i]) begin
                        bus.m_arvalid[i] = 1'b0;
                        mph[i] = 2;
                    end
                    if (mph[i] == 2 && n_r_hs[i]) mph[i] = 0;
                    if (mph[i] == 0 && mq[i].size() > 0) begin
                        bus.m_araddr[32*i +: 32] = mq[i].pop_front();
                        bus.m_arvalid[i] = 1'b1;
                        mph[i] = 1;
                    end
                end
            end
            if (n_rst) begin
                sph = 0; scnt = 0;
                bus.s_rvalid  = 1'b0;
                bus.s_arready = (ar_wait == 0);
            end else begin
                if (sph == 2 && n_s_r_hs) begin
                    bus.s_rvalid = 1'b0;
                    sph = 0; scnt = 0;
                end
                if (sph == 0) begin
                    if (n_s_ar_hs) begin
                        bus.s_arready = 1'b0;
                        sph = 1; scnt = 0;
                    end else begin
                        if (n_s_arvalid) scnt++;
                        bus.s_arready = (scnt >= ar_wait);
                    end
                end
                if (sph == 1) begin
                    if (scnt >= r_wait && sq.size() > 0) begin
                        beat = sq.pop_front();
                        bus.s_rdata  = beat[33:2];
                        bus.s_rresp  = beat[1:0];
                        bus.s_rvalid = 1'b1;
                        sph = 2;
                    end else begin
                        scnt++;
                    end
                end
            end
        end
    end

    task automatic issue(input int m, input logic [31:0] a, input logic [31:0] d, input logic [1:0] rs);
        mq[m].push_back(a);
        exp_ar.push_back('{m: m, addr: a});
        exp_r.push_back('{m: m, data: d, resp: rs});
        sq.push_back({d, rs});
    endtask

    task automatic wait_done(input string name, input int maxc);
        int n = 0;
        while ((exp_ar.size() != 0 || exp_r.size() != 0 || arb_busy) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= maxc) begin
            miscompares++;
            $display("FAIL %s_done: still busy after %0d cycles (ar left %0d, r left %0d), expected completion",
                     name, n, exp_ar.size(), exp_r.size());
        end
    endtask

    initial begin
        int idle_cnt, seen0, n;
        rst = 1'b1;
        bus.m_rready = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arb_busy", arb_busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_s_arvalid", bus.s_arvalid, 0);
        check("rst_s_rready", bus.s_rready, 0);
        check("rst_m_arready", bus.m_arready, 0);
        check("rst_m_rvalid", bus.m_rvalid, 0);
        rst = 1'b0;

        // Both masters request together: master 0 first, then master 1.
        @(negedge clk);
        issue(0, 32'h0000_1000, 32'h1111_1111, 2'b00);
        issue(1, 32'h0000_2000, 32'h2222_2222, 2'b00);
        @(posedge clk); #2;
        check("t1_req_seen", bus.m_arvalid, 2'b11);
        check("t1_idle_s_arvalid", bus.s_arvalid, 0);
        @(posedge clk); #2;
        check("t1_s_arvalid_next", bus.s_arvalid, 1);
        check("t1_first_grant", grant_id, 0);
        @(negedge clk);
        wait_done("t1", 60);

        // Lone master 1, three back-to-back reads: pattern A D I A D I A D.
        @(negedge clk);
        issue(1, 32'h8000_0000, 32'hA000_0000, 2'b00);
        issue(1, 32'h8000_0004, 32'hA000_0004, 2'b00);
        issue(1, 32'h8000_0008, 32'hA000_0008, 2'b00);
        n = 0;
        while (!arb_busy && n < 10) begin @(negedge clk); n++; end
        idle_cnt = 0; seen0 = 0;
        for (int k = 0; k < 8; k++) begin
            if (!arb_busy) idle_cnt++;
            if (bus.m_arready[0] || bus.m_rvalid[0]) seen0++;
            @(negedge clk);
        end
        check("t2_idle_cycles", idle_cnt, 2);
        check("t2_master0_quiet", seen0, 0);
        wait_done("t2", 40);

        // Slow slave: address stalls 5 cycles, data 3 cycles late.
        @(negedge clk);
        ar_wait = 5; r_wait = 3;
        n = rv_cycles;
        issue(0, 32'h3000_0040, 32'h3333_3333, 2'b00);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (arb_busy && bus.s_arvalid) begin
                check("t3_addr_stable", bus.s_araddr, 32'h3000_0040);
                check("t3_arready_mirror", bus.m_arready[0], bus.s_arready);
            end
        end
        wait_done("t3", 20);
        check("t3_rvalid_pulses", rv_cycles - n, 1);

        // Error response passes through and completes.
        ar_wait = 0; r_wait = 0;
        @(negedge clk);
        issue(0, 32'h4000_0000, 32'hDEAD_BEEF, 2'b10);
        wait_done("t4", 40);
        check("t4_back_idle", arb_busy, 0);

        // Reset while master 1 waits in DATA with a silent slave.
        @(negedge clk);
        mq[1].push_back(32'h5000_0000);
        exp_ar.push_back('{m: 1, addr: 32'h5000_0000});
        n = 0;
        while (!(arb_busy && !bus.s_arvalid && exp_ar.size() == 0) && n < 20) begin @(negedge clk); n++; end
        check("t5_reached_data", n < 20, 1);
        rst = 1'b1;
        @(posedge clk); #2;
        check("t5_busy", arb_busy, 0);
        check("t5_s_arvalid", bus.s_arvalid, 0);
        check("t5_s_rready", bus.s_rready, 0);
        check("t5_m_arready", bus.m_arready, 0);
        check("t5_m_rvalid", bus.m_rvalid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(0, 32'h6000_0000, 32'h6666_6666, 2'b00);
        issue(1, 32'h7000_0000, 32'h7777_7777, 2'b00);
        wait_done("t5", 60);

`ifdef MEM_RD_ARB_TIMEOUT_EN
        // Silent slave: error beat after TMO DATA cycles.
        @(negedge clk);
        mq[0].push_back(32'h9000_0000);
        exp_ar.push_back('{m: 0, addr: 32'h9000_0000});
        exp_r.push_back('{m: 0, data: 32'h0, resp: 2'b11});
        wait_done("t6", 60);
        check("t6_timeout_latency", r_cyc - ar_cyc, TMO + 1);
        check("t6_back_idle", arb_busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
